// File: rtl/serial2d_mac_sequencer.sv
// serial2d_mac_sequencer
// Sequences a digit-serial 2D MAC. Each accepted (w, a) pair is split into
// m activation digits and n weight digits, set by the latched precision
// mode. The sequencer walks the m*n partial products one per clock in
// anti-diagonal order (i = a_sel + w_sel), so the MAC can shift its
// accumulator once at the start of each new diagonal.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_load, cfg_mode  load a precision code (taken only when idle)
//   in_valid, in_ready  operand pair handshake
//   w_in, a_in          signed weight / unsigned activation
//   acc_clear           start a fresh accumulation with this pair
//   mode, w, a          latched code and operands toward the MAC
//   w_sel, a_sel        digit selects for the current step
//   shift_ctr           first step of diagonal i>0 (shift accumulator)
//   sign_ctr            step uses the top (signed) weight digit
//   rst_mult            first step of an operation
//   acc_rst             clear the accumulator (first step, acc_clear pairs)
//   busy, done          running / last step of an operation
//   cfg_err             sticky flag for a rejected cfg_mode code
module serial2d_mac_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_load,
  input  logic [3:0] cfg_mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] w_in,
  input  logic [7:0] a_in,
  input  logic       acc_clear,
  output logic [3:0] mode,
  output logic [7:0] w,
  output logic [7:0] a,
  output logic [1:0] w_sel,
  output logic [1:0] a_sel,
  output logic       shift_ctr,
  output logic       sign_ctr,
  output logic       rst_mult,
  output logic       acc_rst,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_n;
  logic [2:0] i_q, i_n;          // current diagonal index
  logic [1:0] j_n, a_sel_n;      // w_sel holds the current j
  logic [3:0] mode_n;
  logic [7:0] w_n, a_n;
  logic       shift_n, sign_n, rstm_n, accr_n, done_n, err_n;
  logic [3:0] m, n, n_m1, last_i;
  logic       accept, cfg_legal;

  // digits per operand for the latched mode
  always_comb begin
    m = 4'd4;
    n = 4'd4;
    case (mode)
      4'b0111: begin m = 4'd2; n = 4'd2; end
      4'b1111: begin m = 4'd1; n = 4'd1; end
      4'b0001: begin m = 4'd4; n = 4'd2; end
      4'b0011: begin m = 4'd4; n = 4'd1; end
      default: begin m = 4'd4; n = 4'd4; end
    endcase
  end

  assign n_m1   = n - 4'd1;
  assign last_i = m + n - 4'd2;

  always_comb begin
    case (cfg_mode)
      4'b0000, 4'b0111, 4'b1111, 4'b0001, 4'b0011: cfg_legal = 1'b1;
      default:                                     cfg_legal = 1'b0;
    endcase
  end

  // ready while idle, and on the last step so pairs chain without a bubble
  assign in_ready = (state == IDLE) | done;
  assign accept   = in_valid & in_ready;
  assign busy     = (state == RUN);

  always_comb begin
    state_n = state;
    mode_n  = mode;
    err_n   = cfg_err;
    w_n     = w;
    a_n     = a;
    i_n     = 3'd0;
    j_n     = 2'd0;
    shift_n = 1'b0;
    sign_n  = 1'b0;
    rstm_n  = 1'b0;
    accr_n  = 1'b0;
    done_n  = 1'b0;
    if (accept) begin
      // acceptance wins over a simultaneous cfg_load
      state_n = RUN;
      w_n     = w_in;
      a_n     = a_in;
      rstm_n  = 1'b1;
      accr_n  = acc_clear;
      sign_n  = (n_m1 == 4'd0);
      done_n  = (last_i == 4'd0);
    end else if (state == RUN && !done) begin
      if (({2'b00, w_sel} < {1'b0, i_q}) && ({2'b00, w_sel} < n_m1)) begin
        // more steps on this diagonal
        i_n = i_q;
        j_n = w_sel + 2'd1;
      end else begin
        // next diagonal starts at j = max(0, i+1-m+1); result fits in 2 bits
        i_n     = i_q + 3'd1;
        shift_n = 1'b1;
        j_n     = (({1'b0, i_q} + 4'd2) > m) ? (i_q[1:0] + 2'd2 - m[1:0]) : 2'd0;
      end
      sign_n = ({2'b00, j_n} == n_m1);
      done_n = ({1'b0, i_n} == last_i);
    end else begin
      state_n = IDLE;
      if (state == IDLE && cfg_load) begin
        if (cfg_legal) begin
          mode_n = cfg_mode;
          err_n  = 1'b0;
        end else begin
          err_n  = 1'b1;
        end
      end
    end
    a_sel_n = i_n[1:0] - j_n;  // i-j never exceeds 3
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= 4'b0000;
      cfg_err   <= 1'b0;
      w         <= 8'd0;
      a         <= 8'd0;
      i_q       <= 3'd0;
      w_sel     <= 2'd0;
      a_sel     <= 2'd0;
      shift_ctr <= 1'b0;
      sign_ctr  <= 1'b0;
      rst_mult  <= 1'b0;
      acc_rst   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      cfg_err   <= err_n;
      w         <= w_n;
      a         <= a_n;
      i_q       <= i_n;
      w_sel     <= j_n;
      a_sel     <= a_sel_n;
      shift_ctr <= shift_n;
      sign_ctr  <= sign_n;
      rst_mult  <= rstm_n;
      acc_rst   <= accr_n;
      done      <= done_n;
    end
  end

endmodule

// File: doc/serial2d_mac_sequencer.md
SERIAL2D_MAC_SEQUENCER -- requirements
Module: serial2d_mac_sequencer

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, reset, synchronous, active-high.
REQ-002 SHALL have cfg_load input 1, request to latch cfg_mode (honoured only in IDLE).
REQ-003 SHALL have cfg_mode input 4, precision code: 0000 A8xW8, 0111 A4xW4, 1111 A2xW2, 0001 A8xW4, 0011 A8xW2.
REQ-004 SHALL have in_valid input 1, operand pair valid; in_ready output 1, sequencer can accept a pair.
REQ-005 SHALL have w_in input 8, signed weight; a_in input 8, unsigned activation; acc_clear input 1, start a new accumulation with this pair.
REQ-006 SHALL have mode output 4 (latched code); w output 8; a output 8; w_sel output 2; a_sel output 2; shift_ctr output 1; sign_ctr output 1; rst_mult output 1; acc_rst output 1, all toward the MAC.
REQ-007 SHALL have busy output 1; done output 1, last step of an operation; cfg_err output 1, sticky illegal-code flag.

Function
REQ-008 SHALL derive m (activation digits) and n (weight digits) from the latched mode: 0000 m4 n4; 0111 m2 n2; 1111 m1 n1; 0001 m4 n2; 0011 m4 n1.
REQ-009 SHALL implement states IDLE and RUN; IDLE->RUN on in_valid&in_ready; RUN->IDLE after the last step unless a new pair is accepted in that cycle.
REQ-010 SHALL assert in_ready in IDLE and in the last RUN step; in_ready SHALL be 0 in all other RUN steps.
REQ-011 SHALL register w_in/a_in into w/a on acceptance and hold them stable until the next acceptance.
REQ-012 SHALL execute one step per clock, iterating i = 0..m+n-2 and, for each i, j = max(0,i-m+1)..min(i,n-1), for m*n steps total.
REQ-013 SHALL output, per step: a_sel = i-j; w_sel = j; sign_ctr = 1 if j==n-1, else 0.
REQ-014 SHALL assert shift_ctr = 1 on the first step of each i>0, otherwise 0.
REQ-015 SHALL assert rst_mult = 1 only on the first step (i=0) of each operation.
REQ-016 SHALL present step 1 in the cycle after acceptance; back-to-back pairs SHALL produce no idle cycle between operations.
REQ-017 SHALL assert acc_rst for exactly one cycle, coincident with step 1, when the accepted pair had acc_clear=1.
REQ-018 SHALL assert done for one cycle on the last step; busy = 1 in RUN, 0 in IDLE.
REQ-019 SHALL drive all MAC-facing outputs from registers.
REQ-020 SHALL, on cfg_load in IDLE with a legal code, update mode on the next cycle and clear cfg_err.
REQ-021 SHALL, on cfg_load with an illegal code, leave mode unchanged and set cfg_err.
REQ-022 SHALL ignore cfg_load in RUN: mode unchanged, no error.
REQ-023 SHALL give acceptance priority when cfg_load and in_valid coincide in IDLE: the pair runs with the old mode and cfg_load is dropped.
REQ-024 SHALL drive shift_ctr, sign_ctr, rst_mult, acc_rst, done = 0 and w_sel = a_sel = 0 in IDLE.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, enter IDLE; mode=0000; w=a=0; all selects and flags 0; cfg_err=0; in_ready=1 in the following cycle.
REQ-026 SHALL, on rst mid-RUN, abort the operation with no done pulse, and SHALL issue no acc_rst.

Verification
REQ-027 SHALL cover mode 0111, pair w=0x0A, a=0x03 -> 4 steps: (a_sel,w_sel) = (0,0), (1,0), (0,1), (1,1); shift_ctr 0,1,0,1; sign_ctr 0,0,1,1; rst_mult 1,0,0,0; done on step 4.
REQ-028 SHALL cover mode 0011 -> 4 steps: a_sel 0,1,2,3; w_sel 0; sign_ctr 1,1,1,1; shift_ctr 0,1,1,1.
REQ-029 SHALL cover mode 0000 with in_valid held high for 3 pairs -> 48 contiguous busy cycles, in_ready high only on steps 16, 32 and 48, with rst_mult on steps 1, 17 and 33.
REQ-030 SHALL cover cfg_load with code 0101 -> cfg_err=1 and mode stays 0000; a subsequent cfg_load with 1111 -> cfg_err=0 and 1-step operations, each with rst_mult=1, sign_ctr=1 and done=1.
REQ-031 SHALL cover rst asserted on step 7 of a mode 0000 operation -> next cycle IDLE, done never pulsed, outputs 0.
REQ-032 SHALL cover acc_clear=1 on the first pair only -> acc_rst pulses once, on step 1 of that pair.
